// File: rtl/rdp_tag_match_cntl.sv
// rdp_tag_match_cntl: tag table plus packet router from the upstream stack bus to the NoC data path.
//   Build option: RDP_TAG_MATCH_STATS_EN adds 16-bit saturating pkt/miss/dup counters.
//   cntl encoding: MOM=2'b00, SOM=2'b01, EOM=2'b10, SOM_EOM=2'b11 (bit0 = start, bit1 = end).
//   Ports:
//     clk, reset_poweron_n        clock, asynchronous active-low reset
//     sys__mgr__mgrId             manager id, registered into rdp__noc__dp_type with each beat
//     wud__rdp__*/rdp__wud__ready descriptor allocate channel {tag, peId, laneId}
//     stuc__rdp__*/rdp__stuc__ready upstream beats {cntl, tag, data}
//     rdp__noc__dp_*/noc__rdp__dp_ready registered NoC beat {cntl, peId, laneId, data, type}
//     rdp__sys__miss/dup          one-cycle event pulses
//     rdp__sys__*_cnt             statistics (RDP_TAG_MATCH_STATS_EN only)
module rdp_tag_match_cntl #(
  parameter int TAG_W      = 8,
  parameter int DATA_W     = 64,
  parameter int TAG_DEPTH  = 8,
  parameter int PE_ID_W    = 6,
  parameter int LANE_ID_W  = 5,
  parameter int MGR_MGR_ID = 4
) (
  input  logic                  clk,
  input  logic                  reset_poweron_n,
  input  logic [MGR_MGR_ID-1:0] sys__mgr__mgrId,
  input  logic                  wud__rdp__valid,
  output logic                  rdp__wud__ready,
  input  logic [TAG_W-1:0]      wud__rdp__tag,
  input  logic [PE_ID_W-1:0]    wud__rdp__peId,
  input  logic [LANE_ID_W-1:0]  wud__rdp__laneId,
  input  logic                  stuc__rdp__valid,
  input  logic [1:0]            stuc__rdp__cntl,
  output logic                  rdp__stuc__ready,
  input  logic [TAG_W-1:0]      stuc__rdp__tag,
  input  logic [DATA_W-1:0]     stuc__rdp__data,
  input  logic                  noc__rdp__dp_ready,
  output logic                  rdp__noc__dp_valid,
  output logic [1:0]            rdp__noc__dp_cntl,
  output logic [PE_ID_W-1:0]    rdp__noc__dp_peId,
  output logic [LANE_ID_W-1:0]  rdp__noc__dp_laneId,
  output logic [DATA_W-1:0]     rdp__noc__dp_data,
  output logic [MGR_MGR_ID-1:0] rdp__noc__dp_type,
  output logic                  rdp__sys__miss,
  output logic                  rdp__sys__dup
`ifdef RDP_TAG_MATCH_STATS_EN
  ,
  output logic [15:0]           rdp__sys__pkt_cnt,
  output logic [15:0]           rdp__sys__miss_cnt,
  output logic [15:0]           rdp__sys__dup_cnt
`endif
);
  localparam int IW = $clog2(TAG_DEPTH);
  localparam int CW = IW + 1;
  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
  state_t state, state_nx;
  logic [TAG_DEPTH-1:0] ent_v;
  logic [TAG_W-1:0]     ent_tag  [TAG_DEPTH];
  logic [PE_ID_W-1:0]   ent_pe   [TAG_DEPTH];
  logic [LANE_ID_W-1:0] ent_lane [TAG_DEPTH];
  logic [CW-1:0]        count;
  logic [IW-1:0]        cur_idx, up_idx, aidx, fidx;
  logic [PE_ID_W-1:0]   cur_pe;
  logic [LANE_ID_W-1:0] cur_lane;
  logic up_hit, wud_hit, aidx_ok, out_ready, up_fire, wud_fire, is_som, is_eom;
  logic emit, latch, free, alloc, miss_nx;
  assign rdp__wud__ready  = count < CW'(TAG_DEPTH);
  assign out_ready        = !rdp__noc__dp_valid || noc__rdp__dp_ready;
  assign rdp__stuc__ready = (state == DROP) || out_ready;
  assign up_fire          = stuc__rdp__valid && rdp__stuc__ready;
  assign wud_fire         = wud__rdp__valid && rdp__wud__ready;
  assign is_som           = stuc__rdp__cntl[0];
  assign is_eom           = stuc__rdp__cntl[1];
  // Lookups see the table as it stands before this edge: an entry freed this
  // cycle still counts as resident for duplicates and is not yet reusable.
  always_comb begin
    up_hit  = 1'b0;
    up_idx  = '0;
    wud_hit = 1'b0;
    aidx_ok = 1'b0;
    aidx    = '0;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      if (ent_v[i] && ent_tag[i] == stuc__rdp__tag) begin
        up_hit = 1'b1;
        up_idx = IW'(i);
      end
      if (ent_v[i] && ent_tag[i] == wud__rdp__tag) wud_hit = 1'b1;
      if (!ent_v[i] && !aidx_ok) begin
        aidx_ok = 1'b1;
        aidx    = IW'(i);
      end
    end
  end
  assign alloc = wud_fire && !wud_hit && aidx_ok;
  always_comb begin
    state_nx = state;
    emit     = 1'b0;
    latch    = 1'b0;
    free     = 1'b0;
    fidx     = cur_idx;
    miss_nx  = 1'b0;
    case (state)
      IDLE: if (up_fire && is_som) begin
        if (up_hit) begin
          emit     = 1'b1;
          latch    = 1'b1;
          free     = is_eom;
          fidx     = up_idx;
          state_nx = is_eom ? IDLE : FWD;
        end else begin
          miss_nx  = 1'b1;
          state_nx = is_eom ? IDLE : DROP;
        end
      end
      FWD: if (up_fire) begin
        emit     = 1'b1;
        free     = is_eom;
        state_nx = is_eom ? IDLE : FWD;
      end
      DROP: if (up_fire && is_eom) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      ent_v <= '0;
      count <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        ent_tag[i]  <= '0;
        ent_pe[i]   <= '0;
        ent_lane[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        if (free && fidx == IW'(i)) ent_v[i] <= 1'b0;
        if (alloc && aidx == IW'(i)) begin
          ent_v[i]    <= 1'b1;
          ent_tag[i]  <= wud__rdp__tag;
          ent_pe[i]   <= wud__rdp__peId;
          ent_lane[i] <= wud__rdp__laneId;
        end
      end
      count <= count + CW'(alloc) - CW'(free);
    end
  end
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state    <= IDLE;
      cur_idx  <= '0;
      cur_pe   <= '0;
      cur_lane <= '0;
    end else begin
      state <= state_nx;
      if (latch) begin
        cur_idx  <= up_idx;
        cur_pe   <= ent_pe[up_idx];
        cur_lane <= ent_lane[up_idx];
      end
    end
  end
  // A new beat is only produced when the output slot is free or draining.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      rdp__noc__dp_valid  <= 1'b0;
      rdp__noc__dp_cntl   <= '0;
      rdp__noc__dp_peId   <= '0;
      rdp__noc__dp_laneId <= '0;
      rdp__noc__dp_data   <= '0;
      rdp__noc__dp_type   <= '0;
      rdp__sys__miss      <= 1'b0;
      rdp__sys__dup       <= 1'b0;
    end else begin
      rdp__sys__miss <= miss_nx;
      rdp__sys__dup  <= wud_fire && wud_hit;
      if (emit) begin
        rdp__noc__dp_valid  <= 1'b1;
        rdp__noc__dp_cntl   <= stuc__rdp__cntl;
        rdp__noc__dp_peId   <= latch ? ent_pe[up_idx] : cur_pe;
        rdp__noc__dp_laneId <= latch ? ent_lane[up_idx] : cur_lane;
        rdp__noc__dp_data   <= stuc__rdp__data;
        rdp__noc__dp_type   <= sys__mgr__mgrId;
      end else if (noc__rdp__dp_ready) begin
        rdp__noc__dp_valid  <= 1'b0;
      end
    end
  end
`ifdef RDP_TAG_MATCH_STATS_EN
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      rdp__sys__pkt_cnt  <= '0;
      rdp__sys__miss_cnt <= '0;
      rdp__sys__dup_cnt  <= '0;
    end else begin
      if (emit && is_eom && ~&rdp__sys__pkt_cnt) rdp__sys__pkt_cnt <= rdp__sys__pkt_cnt + 16'd1;
      if (miss_nx && ~&rdp__sys__miss_cnt) rdp__sys__miss_cnt <= rdp__sys__miss_cnt + 16'd1;
      if (wud_fire && wud_hit && ~&rdp__sys__dup_cnt) rdp__sys__dup_cnt <= rdp__sys__dup_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rdp_tag_match_cntl.sv
// tb_rdp_tag_match_cntl: directed and randomized checks of rdp_tag_match_cntl against a queue-based model.
module tb_rdp_tag_match_cntl;
  localparam int DEPTH = 8;
  localparam logic [1:0] C_MOM = 2'd0, C_SOM = 2'd1, C_EOM = 2'd2, C_SE = 2'd3;
  typedef struct packed {logic [7:0] tag; logic [5:0] pe; logic [4:0] lane;} ent_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] mgr;
  logic wv, wrdy, sv, srdy, nrdy, dv, miss, dup;
  logic [7:0] wtag, stag;
  logic [5:0] wpe, dpe;
  logic [4:0] wlane, dlane;
  logic [1:0] scntl, dc;
  logic [63:0] sdata, dd;
  logic [3:0] dt;
`ifdef RDP_TAG_MATCH_STATS_EN
  logic [15:0] pkt_cnt, miss_cnt, dup_cnt;
`endif
  int n_cmp, n_bad;
  ent_t tbl[$];
  ent_t cur;
  int mode;
  logic ov, e_miss, e_dup;
  logic [1:0] oc;
  logic [63:0] od;
  logic [5:0] ope;
  logic [4:0] olane;
  logic [3:0] ot;
  int e_pkt, e_mc, e_dc;
  always #5 clk = ~clk;
  rdp_tag_match_cntl dut (
    .clk(clk), .reset_poweron_n(rst_n), .sys__mgr__mgrId(mgr),
    .wud__rdp__valid(wv), .rdp__wud__ready(wrdy), .wud__rdp__tag(wtag),
    .wud__rdp__peId(wpe), .wud__rdp__laneId(wlane),
    .stuc__rdp__valid(sv), .stuc__rdp__cntl(scntl), .rdp__stuc__ready(srdy),
    .stuc__rdp__tag(stag), .stuc__rdp__data(sdata),
    .noc__rdp__dp_ready(nrdy), .rdp__noc__dp_valid(dv), .rdp__noc__dp_cntl(dc),
    .rdp__noc__dp_peId(dpe), .rdp__noc__dp_laneId(dlane), .rdp__noc__dp_data(dd),
    .rdp__noc__dp_type(dt), .rdp__sys__miss(miss), .rdp__sys__dup(dup)
`ifdef RDP_TAG_MATCH_STATS_EN
    , .rdp__sys__pkt_cnt(pkt_cnt), .rdp__sys__miss_cnt(miss_cnt), .rdp__sys__dup_cnt(dup_cnt)
`endif
  );
  function automatic int find(input logic [7:0] t);
    foreach (tbl[i]) if (tbl[i].tag == t) return i;
    return -1;
  endfunction
  function automatic logic exp_wr();
    return tbl.size() < DEPTH;
  endfunction
  function automatic logic exp_ur();
    return mode == 2 || !ov || nrdy;
  endfunction
  task automatic model_reset();
    tbl.delete();
    mode = 0; ov = 0; e_miss = 0; e_dup = 0;
    e_pkt = 0; e_mc = 0; e_dc = 0;
  endtask
  // Packet-level model: table is an unordered list of resident tags; mode 0/1/2 = waiting/forwarding/dropping.
  task automatic model_step();
    logic wf, uf, som, eom, emit, nm;
    int h, fi;
    wf = wv && exp_wr();
    uf = sv && exp_ur();
    som = scntl == C_SOM || scntl == C_SE;
    eom = scntl == C_EOM || scntl == C_SE;
    emit = 0; nm = 0; fi = -1;
    h = find(stag);
    if (uf) begin
      if (mode == 0 && som) begin
        if (h >= 0) begin
          emit = 1; cur = tbl[h];
          if (eom) fi = h; else mode = 1;
        end else begin
          nm = 1;
          if (!eom) mode = 2;
        end
      end else if (mode == 1) begin
        emit = 1;
        if (eom) begin fi = find(cur.tag); mode = 0; end
      end else if (mode == 2 && eom) mode = 0;
    end
    e_dup = wf && find(wtag) >= 0;
    e_miss = nm;
    if (ov && nrdy) ov = 0;
    if (emit) begin ov = 1; oc = scntl; od = sdata; ope = cur.pe; olane = cur.lane; ot = mgr; end
    if (emit && eom && e_pkt < 65535) e_pkt++;
    if (nm && e_mc < 65535) e_mc++;
    if (e_dup && e_dc < 65535) e_dc++;
    if (fi >= 0) tbl.delete(fi);
    if (wf && !e_dup) tbl.push_back({wtag, wpe, wlane});
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    wv = 0; wtag = 0; wpe = 0; wlane = 0;
    sv = 0; scntl = C_MOM; stag = 0; sdata = 0;
    nrdy = 1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    idle();
    model_reset();
    #1;
    n_cmp++;
    if (dv !== 0 || miss !== 0 || dup !== 0 || dc !== 0 || dpe !== 0 || dlane !== 0 || dd !== 0 || dt !== 0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b miss=%b dup=%b c=%0d pe=%0d lane=%0d d=%h t=%0d want all 0", dv, miss, dup, dc, dpe, dlane, dd, dt);
    end
    n_cmp++;
    if (wrdy !== 1 || int'(dut.count) !== 0) begin
      n_bad++; $display("FAIL reset_ready: got wrdy=%b count=%0d want 1/0", wrdy, dut.count);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    n_cmp++;
    if (wrdy !== 1 || srdy !== 1) begin
      n_bad++; $display("FAIL reset_release: got wrdy=%b srdy=%b want 1/1", wrdy, srdy);
    end
`ifdef RDP_TAG_MATCH_STATS_EN
    n_cmp++;
    if (pkt_cnt !== 0 || miss_cnt !== 0 || dup_cnt !== 0) begin
      n_bad++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", pkt_cnt, miss_cnt, dup_cnt);
    end
`endif
    @(negedge clk);
  endtask
  task automatic test_basic();
    logic [63:0] d[3];
    logic [1:0] c[3];
    d = '{64'hA, 64'hB, 64'hC};
    c = '{C_SOM, C_MOM, C_EOM};
    do_reset();
    mgr = 4'h5;
    wv = 1; wtag = 8'h11; wpe = 3; wlane = 2;
    #1;
    n_cmp++;
    if (wrdy !== 1) begin n_bad++; $display("FAIL basic_alloc: got wrdy=%b want 1", wrdy); end
    tick();
    wv = 0;
    for (int k = 0; k < 4; k++) begin
      sv = k < 3; scntl = k < 3 ? c[k] : C_MOM; stag = 8'h11; sdata = k < 3 ? d[k] : 64'h0;
      #1;
      n_cmp++;
      if (k == 0 && dv !== 0) begin n_bad++; $display("FAIL basic_latency: got v=%b want 0", dv); end
      if (k > 0 && (dv !== 1 || dd !== d[k-1] || dc !== c[k-1] || dpe !== 3 || dlane !== 2 || dt !== 4'h5)) begin
        n_bad++;
        $display("FAIL basic_beat%0d: got v=%b d=%h c=%0d pe=%0d lane=%0d t=%0d want v=1 d=%h c=%0d pe=3 lane=2 t=5", k - 1, dv, dd, dc, dpe, dlane, dt, d[k-1], c[k-1]);
      end
      tick();
    end
    sv = 0;
    #1;
    n_cmp++;
    if (dv !== 0 || int'(dut.count) !== 0) begin
      n_bad++; $display("FAIL basic_end: got v=%b count=%0d want 0/0", dv, dut.count);
    end
    tick();
  endtask
  task automatic test_miss();
    do_reset();
    nrdy = 0;
    for (int k = 0; k < 4; k++) begin
      sv = 1; scntl = k == 0 ? C_SOM : (k == 3 ? C_EOM : C_MOM); stag = 8'h22; sdata = 64'(k);
      #1;
      n_cmp++;
      if (srdy !== 1 || dv !== 0 || miss !== (k == 1)) begin
        n_bad++; $display("FAIL miss_beat%0d: got srdy=%b v=%b miss=%b want 1/0/%b", k, srdy, dv, miss, k == 1);
      end
      tick();
    end
    sv = 0;
    #1;
    n_cmp++;
    if (miss !== 0 || dv !== 0 || int'(dut.count) !== 0) begin
      n_bad++; $display("FAIL miss_end: got miss=%b v=%b count=%0d want 0/0/0", miss, dv, dut.count);
    end
    tick();
  endtask
  task automatic test_full();
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      wv = 1; wtag = 8'(8'h40 + k); wpe = 6'(k + 1); wlane = 5'(k);
      #1;
      n_cmp++;
      if (wrdy !== 1) begin n_bad++; $display("FAIL full_alloc%0d: got wrdy=%b want 1", k, wrdy); end
      tick();
    end
    wtag = 8'h48; wpe = 6'd9; wlane = 5'd8;
    sv = 1; scntl = C_SOM; stag = 8'h40; sdata = 64'h1;
    #1;
    n_cmp++;
    if (wrdy !== 0 || int'(dut.count) !== DEPTH) begin
      n_bad++; $display("FAIL full_ninth: got wrdy=%b count=%0d want 0/%0d", wrdy, dut.count, DEPTH);
    end
    tick();
    scntl = C_EOM; sdata = 64'h2;
    #1;
    n_cmp++;
    if (wrdy !== 0) begin n_bad++; $display("FAIL full_free_same_cycle: got wrdy=%b want 0", wrdy); end
    tick();
    sv = 0;
    #1;
    n_cmp++;
    if (wrdy !== 1 || int'(dut.count) !== DEPTH - 1) begin
      n_bad++; $display("FAIL full_after_free: got wrdy=%b count=%0d want 1/%0d", wrdy, dut.count, DEPTH - 1);
    end
    tick();
    wv = 0; sv = 1; scntl = C_SE; stag = 8'h48; sdata = 64'h3;
    #1;
    n_cmp++;
    if (wrdy !== 0 || int'(dut.count) !== DEPTH) begin
      n_bad++; $display("FAIL full_refill: got wrdy=%b count=%0d want 0/%0d", wrdy, dut.count, DEPTH);
    end
    tick();
    sv = 0;
    #1;
    n_cmp++;
    if (dv !== 1 || dd !== 64'h3 || dpe !== 9 || dlane !== 8 || int'(dut.count) !== DEPTH - 1) begin
      n_bad++; $display("FAIL full_ninth_hit: got v=%b d=%h pe=%0d lane=%0d count=%0d want 1/3/9/8/%0d", dv, dd, dpe, dlane, dut.count, DEPTH - 1);
    end
    tick();
  endtask
  task automatic test_dup();
    do_reset();
    wv = 1; wtag = 8'h05; wpe = 1; wlane = 1;
    #1;
    tick();
    #1;
    n_cmp++;
    if (dup !== 0) begin n_bad++; $display("FAIL dup_first: got dup=%b want 0", dup); end
    tick();
    wv = 0;
    #1;
    n_cmp++;
    if (dup !== 1 || int'(dut.count) !== 1) begin
      n_bad++; $display("FAIL dup_second: got dup=%b count=%0d want 1/1", dup, dut.count);
    end
    tick();
    #1;
    n_cmp++;
    if (dup !== 0) begin n_bad++; $display("FAIL dup_pulse_width: got dup=%b want 0", dup); end
    wv = 1; sv = 1; scntl = C_SE; stag = 8'h05; sdata = 64'h55;
    tick();
    wv = 0; sv = 0;
    #1;
    n_cmp++;
    if (dup !== 1 || int'(dut.count) !== 0 || dv !== 1 || dd !== 64'h55 || dpe !== 1) begin
      n_bad++; $display("FAIL dup_vs_free: got dup=%b count=%0d v=%b d=%h pe=%0d want 1/0/1/55/1", dup, dut.count, dv, dd, dpe);
    end
    tick();
  endtask
  task automatic test_backpressure();
    do_reset();
    wv = 1; wtag = 8'h33; wpe = 7; wlane = 9;
    tick();
    wv = 0; sv = 1; scntl = C_SOM; stag = 8'h33; sdata = 64'h1000;
    tick();
    nrdy = 0; scntl = C_MOM; sdata = 64'h1001;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (dv !== 1 || dd !== 64'h1000 || dc !== C_SOM || dpe !== 7 || dlane !== 9 || srdy !== 0) begin
        n_bad++; $display("FAIL bp_hold%0d: got v=%b d=%h c=%0d pe=%0d lane=%0d srdy=%b want 1/1000/1/7/9/0", k, dv, dd, dc, dpe, dlane, srdy);
      end
      tick();
    end
    nrdy = 1;
    #1;
    n_cmp++;
    if (srdy !== 1 || dd !== 64'h1000) begin
      n_bad++; $display("FAIL bp_release: got srdy=%b d=%h want 1/1000", srdy, dd);
    end
    tick();
    scntl = C_EOM; sdata = 64'h1002;
    #1;
    n_cmp++;
    if (dv !== 1 || dd !== 64'h1001 || dc !== C_MOM) begin
      n_bad++; $display("FAIL bp_mom: got v=%b d=%h c=%0d want 1/1001/0", dv, dd, dc);
    end
    tick();
    sv = 0;
    #1;
    n_cmp++;
    if (dv !== 1 || dd !== 64'h1002 || dc !== C_EOM) begin
      n_bad++; $display("FAIL bp_eom: got v=%b d=%h c=%0d want 1/1002/2", dv, dd, dc);
    end
    tick();
    #1;
    n_cmp++;
    if (dv !== 0 || int'(dut.count) !== 0) begin
      n_bad++; $display("FAIL bp_end: got v=%b count=%0d want 0/0", dv, dut.count);
    end
    tick();
  endtask
  task automatic test_random();
    do_reset();
    mgr = 4'($urandom);
    for (int n = 0; n < 3000; n++) begin
      wv = $urandom_range(0, 3) == 0; wtag = 8'($urandom_range(0, 11));
      wpe = 6'($urandom); wlane = 5'($urandom);
      sv = $urandom_range(0, 1) == 1; scntl = 2'($urandom); stag = 8'($urandom_range(0, 11));
      sdata = {$urandom, $urandom};
      nrdy = $urandom_range(0, 3) != 0;
      #1;
      n_cmp++;
      if (wrdy !== exp_wr()) begin n_bad++; $display("FAIL rnd_wrdy@%0d: got %b want %b", n, wrdy, exp_wr()); end
      n_cmp++;
      if (srdy !== exp_ur()) begin n_bad++; $display("FAIL rnd_srdy@%0d: got %b want %b", n, srdy, exp_ur()); end
      n_cmp++;
      if (dv !== ov) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", n, dv, ov); end
      if (ov) begin
        n_cmp++;
        if (dc !== oc || dd !== od || dpe !== ope || dlane !== olane || dt !== ot) begin
          n_bad++;
          $display("FAIL rnd_beat@%0d: got c=%0d d=%h pe=%0d lane=%0d t=%0d want c=%0d d=%h pe=%0d lane=%0d t=%0d", n, dc, dd, dpe, dlane, dt, oc, od, ope, olane, ot);
        end
      end
      n_cmp++;
      if (miss !== e_miss || dup !== e_dup) begin
        n_bad++; $display("FAIL rnd_pulse@%0d: got miss=%b dup=%b want %b/%b", n, miss, dup, e_miss, e_dup);
      end
      n_cmp++;
      if (int'(dut.count) !== tbl.size()) begin
        n_bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, dut.count, tbl.size());
      end
`ifdef RDP_TAG_MATCH_STATS_EN
      n_cmp++;
      if (int'(pkt_cnt) !== e_pkt || int'(miss_cnt) !== e_mc || int'(dup_cnt) !== e_dc) begin
        n_bad++; $display("FAIL rnd_stats@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", n, pkt_cnt, miss_cnt, dup_cnt, e_pkt, e_mc, e_dc);
      end
`endif
      tick();
    end
    idle();
  endtask
  task automatic test_mid_reset();
    do_reset();
    wv = 1; wtag = 8'h11; wpe = 3; wlane = 2;
    tick();
    wv = 0; sv = 1; scntl = C_SOM; stag = 8'h11; sdata = 64'hA;
    tick();
    scntl = C_MOM; sdata = 64'hB;
    tick();
    sv = 0; nrdy = 0;
    #1;
    n_cmp++;
    if (dv !== 1 || dd !== 64'hB) begin n_bad++; $display("FAIL mrst_pre: got v=%b d=%h want 1/b", dv, dd); end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if (dv !== 0) begin n_bad++; $display("FAIL mrst_async: got v=%b want 0", dv); end
    @(negedge clk);
    rst_n = 1;
    #1;
    n_cmp++;
    if (wrdy !== 1 || int'(dut.count) !== 0 || dv !== 0) begin
      n_bad++; $display("FAIL mrst_release: got wrdy=%b count=%0d v=%b want 1/0/0", wrdy, dut.count, dv);
    end
`ifdef RDP_TAG_MATCH_STATS_EN
    n_cmp++;
    if (pkt_cnt !== 0 || miss_cnt !== 0 || dup_cnt !== 0) begin
      n_bad++; $display("FAIL mrst_stats: got %0d/%0d/%0d want 0/0/0", pkt_cnt, miss_cnt, dup_cnt);
    end
`endif
    nrdy = 1; sv = 1; scntl = C_EOM; stag = 8'h11; sdata = 64'hC;
    tick();
    sv = 0;
    #1;
    n_cmp++;
    if (dv !== 0 || miss !== 0) begin n_bad++; $display("FAIL mrst_no_partial: got v=%b miss=%b want 0/0", dv, miss); end
    tick();
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    mgr = 4'hA;
    test_reset();
    test_basic();
    test_miss();
    test_full();
    test_dup();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rdp_tag_match_cntl.md
RDP_TAG_MATCH_CNTL -- requirements
Module: rdp_tag_match_cntl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- TAG_W, 8, tag width on the WUD and upstream stack bus.
- DATA_W, 64, upstream and NoC data width.
- TAG_DEPTH, 8, number of outstanding WU tag entries (power of 2, 2..32).
- PE_ID_W, 6, destination PE id width.
- LANE_ID_W, 5, destination lane id width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock.
- reset_poweron_n  in  1  asynchronous active-low reset.
- sys__mgr__mgrId  in  MGR_MGR_ID  manager id; placed in output type field bits.
- wud__rdp__valid  in  1  descriptor valid.
- rdp__wud__ready  out  1  descriptor accepted when valid and ready are both high.
- wud__rdp__tag  in  TAG_W  tag to allocate.
- wud__rdp__peId  in  PE_ID_W  destination PE.
- wud__rdp__laneId  in  LANE_ID_W  destination lane.
- stuc__rdp__valid  in  1  upstream beat valid.
- stuc__rdp__cntl  in  2  COMMON_STD_INTF_CNTL SOM/MOM/EOM/SOM_EOM.
- rdp__stuc__ready  out  1  upstream beat accepted when valid and ready are both high.
- stuc__rdp__tag  in  TAG_W  packet tag; sampled on the SOM or SOM_EOM beat only.
- stuc__rdp__data  in  DATA_W  payload.
- noc__rdp__dp_ready  in  1  NoC can accept.
- rdp__noc__dp_valid, rdp__noc__dp_cntl(2), rdp__noc__dp_peId, rdp__noc__dp_laneId, rdp__noc__dp_data  out  NoC data-path beat.
- rdp__sys__miss  out  1  one-cycle pulse when an upstream packet has no tag match.
- rdp__sys__dup  out  1  one-cycle pulse when a descriptor tag is already resident.

Function
REQ-003 The tag table SHALL hold TAG_DEPTH entries of {valid, tag, peId, laneId} plus an occupancy count of width clog2(TAG_DEPTH)+1.
REQ-004 rdp__wud__ready SHALL equal (count < TAG_DEPTH), combinationally.
REQ-005 An accepted descriptor SHALL be written into the lowest-index free entry at the next edge.
REQ-006 An accepted descriptor whose tag matches a valid entry SHALL be consumed without allocation, and rdp__sys__dup SHALL pulse the following cycle.
REQ-007 The FSM SHALL have states IDLE, FWD and DROP.
REQ-008 In IDLE, an SOM or SOM_EOM beat SHALL look up stuc__rdp__tag combinationally against all valid entries.
- On a hit, the hit entry's peId and laneId SHALL be latched for the packet and the FSM SHALL go to FWD (SOM) or stay in IDLE (SOM_EOM).
- On a miss, the FSM SHALL go to DROP (SOM) or stay in IDLE (SOM_EOM), and rdp__sys__miss SHALL pulse.
REQ-009 MOM or EOM beats arriving in IDLE SHALL be accepted and discarded with no pulse.
REQ-010 In IDLE and FWD, rdp__stuc__ready SHALL equal (!rdp__noc__dp_valid || noc__rdp__dp_ready); in DROP it SHALL be 1.
REQ-011 Each beat accepted in FWD, and a matching SOM or SOM_EOM beat accepted in IDLE, SHALL appear on the NoC outputs exactly one cycle later.
- The NoC outputs are registered, and cntl and data pass through unchanged.
REQ-012 rdp__noc__dp_valid SHALL hold, with stable outputs, until noc__rdp__dp_ready is sampled high.
REQ-013 Acceptance of the EOM or SOM_EOM beat of a matched packet SHALL free its entry and return the FSM to IDLE; an EOM beat in DROP SHALL return the FSM to IDLE.
REQ-014 A simultaneous allocate and free SHALL leave count unchanged.
- The freed slot SHALL NOT be reused in that same cycle.
- When the table is full, ready SHALL stay low that cycle.
REQ-015 A descriptor whose tag equals the entry being freed in the same cycle SHALL be treated as a duplicate.
REQ-016 count SHALL never exceed TAG_DEPTH or wrap below 0.

Reset
REQ-017 Assertion of reset_poweron_n low SHALL asynchronously clear the following: all entry valid bits, count, FSM (to IDLE), rdp__noc__dp_valid, rdp__sys__miss, rdp__sys__dup and the statistics counters.
- All other outputs SHALL reset to 0.
- rdp__wud__ready SHALL read 1 after reset.
REQ-018 A reset applied mid-packet SHALL abandon the packet; no partial beat SHALL be emitted after deassertion.
REQ-019 Reset deassertion SHALL be synchronised externally; the block SHALL require no extra cycles after deassertion.

Configuration
REQ-020 With RDP_TAG_MATCH_STATS_EN defined, the block SHALL add three 16-bit saturating outputs:
- rdp__sys__pkt_cnt, counting forwarded EOM/SOM_EOM beats;
- rdp__sys__miss_cnt, counting miss pulses;
- rdp__sys__dup_cnt, counting dup pulses.
REQ-021 Without RDP_TAG_MATCH_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-022 Allocate tag 0x11 (peId 3, lane 2), then send SOM/MOM/EOM with tag 0x11 and data A,B,C, with NoC ready high.
- Required: NoC outputs A,B,C on consecutive cycles, one cycle later, peId 3, lane 2, cntl unchanged.
- Required: count returns to 0.
REQ-023 Send a SOM with tag 0x22 while the table is empty.
- Required: miss pulse; 4 beats dropped with ready high; no NoC valid.
REQ-024 Allocate 8 distinct tags, then a 9th.
- Required: wud ready low.
- Required: freeing one with an EOM in the same cycle as the 9th is presented keeps ready low that cycle; the 9th is accepted the next cycle.
REQ-025 Allocate tag 0x05 twice.
- Required: dup pulse; count is 1.
REQ-026 Hold NoC ready low for 5 cycles during FWD.
- Required: outputs stable; upstream ready low; no beat lost or duplicated.
REQ-027 Assert reset after the MOM of a matched packet.
- Required: NoC valid low immediately; wud ready 1 and count 0 after deassertion.
- With RDP_TAG_MATCH_STATS_EN: counters read 0.
